// File: rtl/comparator_seq_if.sv
// Request/response bundle for the sequential comparator: operands and
// operation in, busy/done/result back out.
interface comparator_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             result;

  // Requester side: issues compares and observes completion.
  modport master (
    output start, a, b, op, is_signed,
    input  busy, done, result
  );

  // Comparator side.
  modport slave (
    input  start, a, b, op, is_signed,
    output busy, done, result
  );
endinterface

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator. Walks the operands CHUNK bits per clock
// from the most significant chunk down, latching the first difference found.
// Signed compares are handled by flipping both sign bits at capture, which
// maps two's-complement ordering onto plain unsigned ordering.
module comparator_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  comparator_seq_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_GE = 3'b001;
  localparam logic [2:0] OP_LE = 3'b010;
  localparam logic [2:0] OP_GT = 3'b011;
  localparam logic [2:0] OP_LT = 3'b100;
  localparam logic [2:0] OP_NE = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [NCHUNK-1:0][CHUNK-1:0]   a_q;
  logic [NCHUNK-1:0][CHUNK-1:0]   b_q;
  logic [2:0]                     op_q;
  logic [IDXW-1:0]                idx_q;
  logic                           gt_q;
  logic                           lt_q;
  logic                           result_q;

  logic [CHUNK-1:0]               chunk_a;
  logic [CHUNK-1:0]               chunk_b;
  logic                           gt_nxt;
  logic                           lt_nxt;
  logic                           last;
  logic                           res_nxt;
  logic                           accept;

  // A new request is taken whenever no compare is in flight.
  assign accept = bus.start && (state != RUN);

  // Current chunk compare; flags only change while no difference is recorded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    chunk_a = a_q[idx_q];
    chunk_b = b_q[idx_q];
    gt_nxt  = gt_q;
    lt_nxt  = lt_q;
    if (!gt_q && !lt_q) begin
      gt_nxt = (chunk_a > chunk_b);
      lt_nxt = (chunk_a < chunk_b);
    end
    last = (idx_q == '0) || ((EARLY_EXIT != 0) && (gt_nxt || lt_nxt));
  end

  // Map the final ordering flags onto the requested operation.
  always_comb begin
    res_nxt = 1'b0;
    case (op_q)
      OP_EQ:   res_nxt = !gt_nxt && !lt_nxt;
      OP_GE:   res_nxt = !lt_nxt;
      OP_LE:   res_nxt = !gt_nxt;
      OP_GT:   res_nxt = gt_nxt;
      OP_LT:   res_nxt = lt_nxt;
      OP_NE:   res_nxt = gt_nxt || lt_nxt;
      default: res_nxt = 1'b0;
    endcase
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture, chunk walk and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      result_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a ^ (bus.is_signed ? MSB_MASK : '0);
      b_q   <= bus.b ^ (bus.is_signed ? MSB_MASK : '0);
      op_q  <= bus.op;
      idx_q <= IDXW'(NCHUNK - 1);
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else if (state == RUN) begin
      gt_q <= gt_nxt;
      lt_q <= lt_nxt;
      if (last) result_q <= res_nxt;
      else      idx_q    <= idx_q - IDXW'(1);
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Multi-cycle, parametrised successor to the combinational 32-bit Comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, walking from MSB to LSB, with optional early exit on the first differing chunk.
- Adds signed/unsigned mode and a start/busy/done handshake.
- Sits beside the ALU in the datapath; used for branch-condition evaluation where a full-width combinational compare would limit timing.

Parameters:
- WIDTH, 32, operand width in bits; must be a positive multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- EARLY_EXIT, 1, 1 = finish on the first unequal chunk; 0 = always scan all NCHUNK chunks.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is ready to accept (IDLE or DONE).
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- op  in  3  operation; captured when start is accepted.
- is_signed  in  1  1 = two's-complement compare; captured when start is accepted.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  1  compare outcome; holds its value until the next done.

Behaviour:
- Reset (synchronous): state=IDLE, busy=0, done=0, result=0; operand, op and chunk-index registers cleared. Reset during RUN aborts the compare and no done is produced.
- Op encoding:
  - 000 a==b
  - 001 a>=b
  - 010 a<=b
  - 011 a>b
  - 100 a<b
  - 101 a!=b
  - 110, 111: result=0 (default).
- Signed mode: on capture, if is_signed=1, invert the MSB of both operands. The unsigned chunk compare then yields two's-complement ordering. is_signed has no effect on 000 or 101.
- States:
  - IDLE -> RUN on start. Capture a, b, op, is_signed; idx=NCHUNK-1; gt_f=0, lt_f=0.
  - RUN: each cycle compare chunk idx of A' against B'.
    - Chunks unequal and no difference recorded yet: set gt_f or lt_f.
    - EARLY_EXIT=1 and a difference is now recorded, or idx==0: go to DONE. On this same edge, register result from gt_f/lt_f (eq = neither set) per op, and set done=1.
    - Otherwise: idx=idx-1.
    - With EARLY_EXIT=0, only the first (most significant) difference is recorded; later chunks do not change the flags.
  - DONE: done=1 for exactly one cycle, busy=0. Then:
    - start=1 in this cycle: accept a new request and go to RUN (back-to-back operation).
    - start=0: go to IDLE.
- Latency: with start sampled at edge t, done=1 after edge t+k, where k = number of chunks examined.
  - k ranges from 1 to NCHUNK.
  - k = NCHUNK when EARLY_EXIT=0 or when the operands are equal.
  - busy=1 after edges t..t+k-1.
- start while busy=1 is ignored, with no effect on captured state.
- Changes on a, b, op or is_signed after capture do not affect the compare in flight.
- No arithmetic carry is involved. Chunk compare is an unsigned CHUNK-bit compare, and the index counter is clog2(NCHUNK) bits wide (minimum 1).
- NCHUNK=1 degenerates to a single-cycle compare: done one cycle after start.

Test Plan:
- All scenarios use WIDTH=32, CHUNK=8, EARLY_EXIT=1 unless stated.
- a=5, b=5, op=000 -> done 4 cycles after the start edge, result=1. Same operands with op=101 -> result=0.
- a=0x80000000, b=1, op=011, is_signed=0 -> done after 1 cycle, result=1. Same with is_signed=1 -> result=0, and op=100 -> result=1.
- a=0x12345678, b=0x12345679, op=100 -> done after 4 cycles, result=1. Rerun with EARLY_EXIT=0 and a=0xFF000000, b=0x00FFFFFF, op=011 -> done after 4 cycles, result=1.
- op=110 and op=111 with any operands -> result=0; done timing unchanged.
- reset asserted on the 2nd RUN cycle -> busy=0, done=0, result=0 on the next edge; no done pulse follows.
- start pulsed while busy=1 with different operands -> ignored; original result returned. start held high in the DONE cycle -> new compare begins, busy=1 on the next cycle, second done correct.
